// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding command to APB master bridge
// Optional ACCESS-phase timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              i_PCLK,
    input  logic              i_PRESETn,
    input  logic              i_CMD_VALID,
    output logic              o_CMD_READY,
    input  logic              i_CMD_WRITE,
    input  logic [ADDR_W-1:0] i_CMD_ADDR,
    input  logic [DATA_W-1:0] i_CMD_WDATA,
    output logic              o_RSP_VALID,
    output logic [DATA_W-1:0] o_RSP_RDATA,
    output logic              o_RSP_TIMEOUT,
    output logic              o_PSEL,
    output logic              o_PENABLE,
    output logic              o_PWRITE,
    output logic [ADDR_W-1:0] o_PADDR,
    output logic [DATA_W-1:0] o_PWDATA,
    input  logic              i_PREADY,
    input  logic [DATA_W-1:0] i_PRDATA
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    logic [1:0] state;
    logic       accept;
    logic       timeout_hit;

    assign accept = (state == ST_IDLE) && o_CMD_READY && i_CMD_VALID;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] wait_cnt;

    // Abort fires on the TIMEOUT_CYC-th stalled ACCESS cycle; a ready slave wins that cycle.
    assign timeout_hit = (state == ST_ACCESS) && !i_PREADY &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            wait_cnt      <= '0;
            o_RSP_TIMEOUT <= 1'b0;
        end else begin
            o_RSP_TIMEOUT <= timeout_hit;
            if (accept) begin
                wait_cnt <= '0;
            end else if (state == ST_ACCESS && !i_PREADY) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign o_RSP_TIMEOUT = 1'b0;
`endif

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state       <= ST_IDLE;
            o_CMD_READY <= 1'b0;
            o_RSP_VALID <= 1'b0;
            o_RSP_RDATA <= '0;
            o_PSEL      <= 1'b0;
            o_PENABLE   <= 1'b0;
            o_PWRITE    <= 1'b0;
            o_PADDR     <= '0;
            o_PWDATA    <= '0;
        end else begin
            o_RSP_VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_SETUP;
                        o_CMD_READY <= 1'b0;
                        o_PSEL      <= 1'b1;
                        o_PENABLE   <= 1'b0;
                        o_PWRITE    <= i_CMD_WRITE;
                        o_PADDR     <= i_CMD_ADDR;
                        // Reads drive zero write data so the bus never shows stale data.
                        o_PWDATA    <= i_CMD_WRITE ? i_CMD_WDATA : '0;
                    end else begin
                        o_CMD_READY <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state     <= ST_ACCESS;
                    o_PENABLE <= 1'b1;
                end
                ST_ACCESS: begin
                    if (i_PREADY || timeout_hit) begin
                        state       <= ST_IDLE;
                        o_CMD_READY <= 1'b1;
                        o_PSEL      <= 1'b0;
                        o_PENABLE   <= 1'b0;
                        o_RSP_VALID <= 1'b1;
                        o_RSP_RDATA <= (i_PREADY && !o_PWRITE) ? i_PRDATA : '0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    o_CMD_READY <= 1'b0;
                    o_PSEL      <= 1'b0;
                    o_PENABLE   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - vector table plus scoreboard bench for apb_master_bridge
module tb_apb_master_bridge;

    localparam int AW = 16;
    localparam int DW = 8;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TCYC = 4;
`else
    localparam int TCYC = 16;
`endif

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          to;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_timeout;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready = 1'b0;
    logic [DW-1:0] prdata = '0;

    int   checks = 0;
    int   errors = 0;
    rsp_t sb[$];
    rsp_t cur_exp;
    rsp_t mon_e;

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TCYC)) dut (
        .i_PCLK(clk), .i_PRESETn(rst_n),
        .i_CMD_VALID(cmd_valid), .o_CMD_READY(cmd_ready), .i_CMD_WRITE(cmd_write),
        .i_CMD_ADDR(cmd_addr), .i_CMD_WDATA(cmd_wdata),
        .o_RSP_VALID(rsp_valid), .o_RSP_RDATA(rsp_rdata), .o_RSP_TIMEOUT(rsp_timeout),
        .o_PSEL(psel), .o_PENABLE(penable), .o_PWRITE(pwrite),
        .o_PADDR(paddr), .o_PWDATA(pwdata), .i_PREADY(pready), .i_PRDATA(prdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Handshakes push the bench's expectation; completions pop and compare.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) sb.push_back(cur_exp);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.to));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_txn(input vec_t v);
        logic          exp_to;
        int            exp_n;
        int            n;
        logic [AW-1:0] a_exp;
        logic [DW-1:0] wd_exp;
        exp_to = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        exp_to = (v.waits >= TCYC);
`endif
        exp_n  = exp_to ? TCYC - 1 : v.waits;
        a_exp  = v.addr;
        wd_exp = v.write ? v.wdata : '0;
        cur_exp.rdata = (v.write || exp_to) ? '0 : v.prdata;
        cur_exp.to    = exp_to;
        cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
        chk("setup_psel", 32'(psel), 32'd1);
        chk("setup_penable", 32'(penable), 32'd0);
        chk("setup_pwrite", 32'(pwrite), 32'(v.write));
        chk("setup_paddr", 32'(paddr), 32'(a_exp));
        chk("setup_pwdata", 32'(pwdata), 32'(wd_exp));
        chk("setup_ready", 32'(cmd_ready), 32'd0);
        pready = 1'b1;
        @(posedge clk); #1;
        chk("access_psel", 32'(psel), 32'd1);
        chk("access_penable", 32'(penable), 32'd1);
        n = -1;
        for (int i = 0; i < 40; i++) begin
            pready = (i == v.waits);
            prdata = (i == v.waits) ? v.prdata : ~v.prdata;
            @(posedge clk); #1;
            if (rsp_valid) begin
                n = i;
                break;
            end
            chk("access_paddr_stable", 32'(paddr), 32'(a_exp));
            chk("access_pwdata_stable", 32'(pwdata), 32'(wd_exp));
            chk("access_penable_hold", 32'(penable), 32'd1);
        end
        pready = 1'b0;
        chk("access_cycles", 32'(n), 32'(exp_n));
        chk("idle_psel", 32'(psel), 32'd0);
        chk("idle_penable", 32'(penable), 32'd0);
        chk("idle_ready", 32'(cmd_ready), 32'd1);
        chk("idle_paddr_hold", 32'(paddr), 32'(a_exp));
        chk("idle_pwdata_hold", 32'(pwdata), 32'(wd_exp));
        @(posedge clk); #1;
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    endtask

    localparam int NV = 6;
    vec_t vecs[NV];
    logic [8:0] exp_psel_pat;
    logic [8:0] exp_rv_pat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{write: 1'b1, addr: 16'h0104, wdata: 8'hA5, waits: 0, prdata: 8'h00};
        vecs[1] = '{write: 1'b0, addr: 16'h0108, wdata: 8'h77, waits: 3, prdata: 8'h3C};
        vecs[2] = '{write: 1'b1, addr: 16'h00FF, wdata: 8'h5A, waits: 1, prdata: 8'h99};
        vecs[3] = '{write: 1'b0, addr: 16'hFFFF, wdata: 8'h00, waits: 0, prdata: 8'h81};
        vecs[4] = '{write: 1'b0, addr: 16'h0000, wdata: 8'h12, waits: 2, prdata: 8'hFF};
        vecs[5] = '{write: 1'b1, addr: 16'h8000, wdata: 8'h00, waits: 3, prdata: 8'h44};

        #2 rst_n = 1'b0;
        #2;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        #1 chk("release_ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("release_ready_high", 32'(cmd_ready), 32'd1);

        for (int k = 0; k < NV; k++) do_txn(vecs[k]);

        // Back-to-back with valid held: 3-cycle period, PSEL rises the cycle after RSP_VALID.
        cur_exp.rdata = '0; cur_exp.to = 1'b0;
        cmd_write = 1'b1; cmd_addr = 16'h0200; cmd_wdata = 8'h11; pready = 1'b1; cmd_valid = 1'b1;
        wait_ready();
        exp_psel_pat = 9'b011011011;
        exp_rv_pat   = 9'b100100100;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            chk("b2b_psel", 32'(psel), 32'(exp_psel_pat[k]));
            chk("b2b_rsp_valid", 32'(rsp_valid), 32'(exp_rv_pat[k]));
        end
        cmd_valid = 1'b0; pready = 1'b0;
        @(posedge clk); #1;

`ifdef APB_MASTER_TIMEOUT_EN
        do_txn('{write: 1'b0, addr: 16'h0400, wdata: 8'h00, waits: 4, prdata: 8'h66});
        do_txn('{write: 1'b1, addr: 16'h0404, wdata: 8'hC3, waits: 9, prdata: 8'h00});
        do_txn('{write: 1'b0, addr: 16'h0408, wdata: 8'h00, waits: 3, prdata: 8'h5E});
`endif

        // Reset mid-ACCESS aborts without a response.
        cur_exp.rdata = 8'hEE; cur_exp.to = 1'b0;
        cmd_write = 1'b0; cmd_addr = 16'h0300; cmd_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        cmd_valid = 1'b0; pready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_penable", 32'(penable), 32'd1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_psel", 32'(psel), 32'd0);
        chk("async_penable", 32'(penable), 32'd0);
        chk("async_ready", 32'(cmd_ready), 32'd0);
        chk("async_paddr", 32'(paddr), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1 chk("rerelease_ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("rerelease_ready_high", 32'(cmd_ready), 32'd1);
        chk("rerelease_no_rsp", 32'(rsp_valid), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        do_txn('{write: 1'b0, addr: 16'h0ABC, wdata: 8'h00, waits: 1, prdata: 8'hD2});
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter: ADDR_W, 16, APB address width.
REQ-002 Parameter: DATA_W, 8, APB data width.
REQ-003 Parameter: TIMEOUT_CYC, 16, ACCESS-phase wait limit in cycles (>=2; used only with timeout enabled).
REQ-004 The clock and reset ports SHALL be:
- i_PCLK  in  1  sole clock, rising edge.
- i_PRESETn  in  1  asynchronous, active-low reset.
REQ-005 The command and response ports SHALL be:
- i_CMD_VALID  in  1  command request.
- o_CMD_READY  out  1  command accepted when high with i_CMD_VALID.
- i_CMD_WRITE  in  1  1=write, 0=read.
- i_CMD_ADDR  in  ADDR_W  target address.
- i_CMD_WDATA  in  DATA_W  write data.
- o_RSP_VALID  out  1  one-cycle completion pulse.
- o_RSP_RDATA  out  DATA_W  read data; 0 for writes.
- o_RSP_TIMEOUT  out  1  completion was a timeout abort.
REQ-006 The APB ports SHALL be:
- o_PSEL, o_PENABLE, o_PWRITE  out  1  APB control.
- o_PADDR  out  ADDR_W.
- o_PWDATA  out  DATA_W.
- i_PREADY  in  1  slave ready.
- i_PRDATA  in  DATA_W  slave read data.

Function
REQ-007 The FSM SHALL have states IDLE, SETUP and ACCESS, and all outputs SHALL be registered.
REQ-008 o_CMD_READY SHALL be 1 only in IDLE; a command is accepted on a rising edge with i_CMD_VALID=1 and o_CMD_READY=1.
REQ-009 On acceptance the block SHALL latch write, address and data into o_PWRITE, o_PADDR and o_PWDATA, and enter SETUP with o_PSEL=1, o_PENABLE=0.
REQ-010 SETUP SHALL last exactly one cycle, then go to ACCESS with o_PSEL=1, o_PENABLE=1.
REQ-011 In ACCESS, o_PADDR, o_PWRITE and o_PWDATA SHALL stay stable until completion.
REQ-012 In ACCESS with i_PREADY=1, the block SHALL go to IDLE on the next edge and SHALL in that edge:
- clear o_PSEL and o_PENABLE;
- pulse o_RSP_VALID for one cycle with o_RSP_TIMEOUT=0;
- load o_RSP_RDATA with i_PRDATA for reads, or 0 for writes.
REQ-013 In IDLE, o_PSEL and o_PENABLE SHALL be 0; o_PADDR, o_PWRITE and o_PWDATA SHALL hold their last values, and o_PWDATA SHALL be 0 after a read.
REQ-014 A new command MAY be accepted in the same IDLE cycle that o_RSP_VALID is high, giving a 3-cycle minimum transfer period.
REQ-015 i_PREADY SHALL be ignored outside ACCESS.
REQ-016 i_CMD_VALID SHALL be ignored while not in IDLE, and no command SHALL be queued.

Reset
REQ-017 Assertion of i_PRESETn=0 SHALL immediately, without waiting for a clock, force:
- state to IDLE;
- o_PSEL, o_PENABLE, o_PWRITE, o_RSP_VALID and o_RSP_TIMEOUT to 0;
- o_PADDR, o_PWDATA and o_RSP_RDATA to 0;
- o_CMD_READY to 0.
REQ-018 o_CMD_READY SHALL go to 1 on the first clock edge after deassertion.
REQ-019 Reset during SETUP or ACCESS SHALL abort the transfer with no o_RSP_VALID.

Configuration
REQ-020 With macro APB_MASTER_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles that have i_PREADY=0.
- When TIMEOUT_CYC such cycles occur, the block SHALL go to IDLE, clear o_PSEL and o_PENABLE, and pulse o_RSP_VALID with o_RSP_TIMEOUT=1 and o_RSP_RDATA=0.
- i_PREADY=1 on the cycle the limit is reached SHALL complete normally with o_RSP_TIMEOUT=0.
- The counter SHALL clear on entry to SETUP.
REQ-021 Without APB_MASTER_TIMEOUT_EN, no counter logic SHALL be present, ACCESS SHALL wait indefinitely, and o_RSP_TIMEOUT SHALL be tied to 0.

Verification
REQ-022 Write addr=0x0104 data=0xA5, i_PREADY held 1 -> SETUP then ACCESS, PSEL/PENABLE 1/0 then 1/1, PWRITE=1, o_RSP_VALID 2 cycles after acceptance, RDATA=0x00.
REQ-023 Read addr=0x0108, i_PREADY=0 for 3 ACCESS cycles then 1 with i_PRDATA=0x3C -> PADDR stable throughout, o_RSP_RDATA=0x3C, TIMEOUT=0.
REQ-024 Back-to-back commands, i_CMD_VALID held high -> second PSEL rises 1 cycle after first o_RSP_VALID, period 3 cycles.
REQ-025 APB_MASTER_TIMEOUT_EN, TIMEOUT_CYC=4, i_PREADY stuck 0 -> abort after 4 ACCESS cycles, o_RSP_TIMEOUT=1, RDATA=0x00; then i_PREADY=1 on the 4th cycle -> normal completion.
REQ-026 i_PRESETn pulsed low mid-ACCESS -> PSEL/PENABLE drop asynchronously, no o_RSP_VALID, o_CMD_READY=1 one edge after release.
